pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 4-stage F/D/E/W pipeline.
- Each cycle it produces the 2-bit update code for the fetch/decode, decode/execute and execute/writeback pipeline registers, plus the PC enable and redirect select.
- Update codes: 2'b01 = advance, 2'b10 = flush (load bubble), 2'b00 = hold.
- It resolves load-use hazards, multi-cycle execute latency, taken branches and jumps, stop/halt and external memory stalls, with a fixed priority.

Parameters:
- WAIT_W, 5, width of the execute wait-time field and the internal countdown counter.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-high.
- mem_busy  in  1  external memory/IO stall; freezes the entire pipeline.
- resume  in  1  leave HALT (1-cycle pulse).
- d_rs  in  7  decode source 1; bit6 = FP file, [5:0] = index.
- d_rt  in  7  decode source 2; same encoding as d_rs.
- d_use_s  in  1  decode instruction reads d_rs.
- d_use_t  in  1  decode instruction reads d_rt.
- de_rw  in  2  execute-stage write enable; nonzero = writes; bit1 = FP file.
- de_rd  in  6  execute-stage destination index.
- de_is_load  in  1  execute-stage instruction is a load (result ready only in W).
- de_wait_time  in  WAIT_W  extra execute cycles required by the execute-stage instruction.
- de_stop  in  1  execute-stage instruction is stop.
- e_redirect  in  1  execute resolved a taken branch, jump or jr.
- fd_update  out  2  fetch/decode register update code.
- de_update  out  2  decode/execute register update code.
- ew_update  out  2  execute/writeback register update code.
- pc_en  out  1  PC register load enable.
- pc_redirect  out  1  PC takes the execute-computed target.
- halted  out  1  high while in HALT.

Behaviour:
- Outputs are combinational from state and inputs; state and counter are registered.
- While rst=1: fd_update/de_update/ew_update = 2'b10, pc_en=0, pc_redirect=0, halted=0; next state RUN, cnt=0.
- Reset asserted mid-WAIT or in HALT returns to RUN on the following edge.
- States: RUN, WAIT, HALT. Register cnt is WAIT_W bits wide.
- Stall action: fd=00, de=00, ew=10, pc_en=0.
- Hazard match for source X: de_rw!=0, de_rw[1]==X[6], de_rd==X[5:0], and not (de_rw[1]==0 && de_rd==0).
- Load-use = de_is_load && ((d_use_s && match d_rs) || (d_use_t && match d_rt)).
- RUN, first matching rule wins:
  1. mem_busy: all updates 00, pc_en=0; stay RUN.
  2. de_stop: fd=00, de=00, ew=10, pc_en=0; go to HALT.
  3. de_wait_time=N, N!=0: stall action; cnt<=N; go to WAIT.
  4. e_redirect: fd=10, de=10, ew=01, pc_en=1, pc_redirect=1.
  5. load-use: fd=00, de=10, ew=01, pc_en=0.
  6. Otherwise: all updates 01, pc_en=1.
- WAIT:
  - mem_busy: all updates 00; cnt frozen.
  - cnt>1: stall action; cnt<=cnt-1.
  - cnt==1: evaluate RUN rules 4-6 (de_wait_time is ignored); go to RUN; cnt<=0.
  - Result: an instruction with wait N occupies E for exactly N+1 cycles and produces N bubbles into W.
- HALT:
  - All updates 00, pc_en=0, halted=1.
  - resume (mem_busy ignored): fd=00, de=10, ew=10, pc_en=0; go to RUN.
- pc_redirect is 1 only under rule 4. e_redirect is never honoured while execute is stalled.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs stall_cnt (32), flush_cnt (32), halt_cnt (32).
  - stall_cnt increments on every cycle with pc_en=0 outside HALT and outside reset.
  - flush_cnt increments on each rule-4 redirect.
  - halt_cnt increments on each cycle with halted=1.
  - All three reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles -> updates 10/10/10, pc_en=0, halted=0. First cycle after release with no hazards -> 01/01/01, pc_en=1.
- Load-use: de_is_load=1, de_rw=01, de_rd=5, d_rs=7'h05, d_use_s=1 -> fd=00, de=10, ew=01, pc_en=0 for one cycle. Same with d_rs=7'h45 (FP file) -> no stall. de_rd=0 with de_rw=01 -> no stall.
- Multi-cycle: de_wait_time=3 -> 3 cycles with ew=10, pc_en=0, then 1 advance cycle (01/01/01). mem_busy pulsed in the 2nd stall cycle -> stall extended by exactly 1 cycle.
- Redirect vs load-use: e_redirect=1 and load-use true in the same cycle -> fd=10, de=10, ew=01, pc_en=1, pc_redirect=1.
- Halt: de_stop=1 -> HALT; halted=1 held for 10 cycles with all updates 00. resume=1 -> de=10, ew=10, pc_en=0; next cycle normal advance.
- PERF (PIPE_CTRL_PERF_EN): run the four scenarios above -> stall_cnt, flush_cnt and halt_cnt match the counts of pc_en=0, pc_redirect and halted cycles.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the F/D/E/W pipeline.
// Define PIPE_CTRL_PERF_EN to add stall/flush/halt event counters.
module pipe_ctrl #(
  parameter int WAIT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_busy,
  input  logic              resume,
  input  logic [6:0]        d_rs,
  input  logic [6:0]        d_rt,
  input  logic              d_use_s,
  input  logic              d_use_t,
  input  logic [1:0]        de_rw,
  input  logic [5:0]        de_rd,
  input  logic              de_is_load,
  input  logic [WAIT_W-1:0] de_wait_time,
  input  logic              de_stop,
  input  logic              e_redirect,
  output logic [1:0]        fd_update,
  output logic [1:0]        de_update,
  output logic [1:0]        ew_update,
  output logic              pc_en,
  output logic              pc_redirect,
`ifdef PIPE_CTRL_PERF_EN
  output logic              halted,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       halt_cnt
`else
  output logic              halted
`endif
);

  localparam logic [1:0] UPD_HOLD  = 2'b00;
  localparam logic [1:0] UPD_ADV   = 2'b01;
  localparam logic [1:0] UPD_FLUSH = 2'b10;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              flow;
  logic              load_use;

  // Integer r0 never creates a dependency; FP f0 does.
  function automatic logic src_hit(
    input logic [6:0] src,
    input logic [1:0] rw,
    input logic [5:0] rd
  );
    src_hit = (rw != 2'b00) && (rw[1] == src[6]) &&
              (rd == src[5:0]) && !(!rw[1] && rd == 6'd0);
  endfunction

  assign load_use = de_is_load &&
    ((d_use_s && src_hit(d_rs, de_rw, de_rd)) ||
     (d_use_t && src_hit(d_rt, de_rw, de_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fd_update   = UPD_HOLD;
    de_update   = UPD_HOLD;
    ew_update   = UPD_HOLD;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    halted      = 1'b0;
    flow        = 1'b0;
    if (rst) begin
      fd_update = UPD_FLUSH;
      de_update = UPD_FLUSH;
      ew_update = UPD_FLUSH;
      state_d   = S_RUN;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (mem_busy) begin
            state_d = S_RUN;
          end else if (de_stop) begin
            ew_update = UPD_FLUSH;
            state_d   = S_HALT;
          end else if (de_wait_time != '0) begin
            ew_update = UPD_FLUSH;
            cnt_d     = de_wait_time;
            state_d   = S_WAIT;
          end else begin
            flow = 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_busy) begin
            cnt_d = cnt_q;
          end else if (cnt_q > WAIT_W'(1)) begin
            ew_update = UPD_FLUSH;
            cnt_d     = cnt_q - WAIT_W'(1);
          end else begin
            flow    = 1'b1;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
        S_HALT: begin
          halted = 1'b1;
          if (resume) begin
            de_update = UPD_FLUSH;
            ew_update = UPD_FLUSH;
            state_d   = S_RUN;
          end
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      endcase

      // Execute is free to move: redirect beats load-use.
      if (flow) begin
        if (e_redirect) begin
          fd_update   = UPD_FLUSH;
          de_update   = UPD_FLUSH;
          ew_update   = UPD_ADV;
          pc_en       = 1'b1;
          pc_redirect = 1'b1;
        end else if (load_use) begin
          fd_update = UPD_HOLD;
          de_update = UPD_FLUSH;
          ew_update = UPD_ADV;
        end else begin
          fd_update = UPD_ADV;
          de_update = UPD_ADV;
          ew_update = UPD_ADV;
          pc_en     = 1'b1;
        end
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, halt_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      halt_cnt_q  <= '0;
    end else begin
      if (!pc_en && state_q != S_HALT)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pc_redirect)
        flush_cnt_q <= flush_cnt_q + 32'd1;
      if (halted)
        halt_cnt_q <= halt_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign halt_cnt  = halt_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random
// traffic checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int WAIT_W = 5;

  localparam logic [8:0] V_RST   = 9'b10_10_10_0_0_0;
  localparam logic [8:0] V_ADV   = 9'b01_01_01_1_0_0;
  localparam logic [8:0] V_LU    = 9'b00_10_01_0_0_0;
  localparam logic [8:0] V_REDIR = 9'b10_10_01_1_1_0;
  localparam logic [8:0] V_STALL = 9'b00_00_10_0_0_0;
  localparam logic [8:0] V_BUSY  = 9'b00_00_00_0_0_0;
  localparam logic [8:0] V_HALT  = 9'b00_00_00_0_0_1;
  localparam logic [8:0] V_RESUM = 9'b00_10_10_0_0_1;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_busy, resume;
  logic [6:0]        d_rs, d_rt;
  logic              d_use_s, d_use_t;
  logic [1:0]        de_rw;
  logic [5:0]        de_rd;
  logic              de_is_load;
  logic [WAIT_W-1:0] de_wait_time;
  logic              de_stop, e_redirect;
  logic [1:0]        fd_update, de_update, ew_update;
  logic              pc_en, pc_redirect, halted;
  logic [8:0]        obs;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: halted flag, remaining cycles of the E-stage instruction.
  bit m_halt = 0;
  int m_rem  = 0;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, halt_cnt;
  int m_stall = 0, m_flush = 0, m_hcnt = 0;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.WAIT_W(WAIT_W)) dut (
    .clk(clk), .rst(rst), .mem_busy(mem_busy), .resume(resume),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_s(d_use_s), .d_use_t(d_use_t),
    .de_rw(de_rw), .de_rd(de_rd), .de_is_load(de_is_load),
    .de_wait_time(de_wait_time), .de_stop(de_stop),
    .e_redirect(e_redirect),
    .fd_update(fd_update), .de_update(de_update),
    .ew_update(ew_update), .pc_en(pc_en),
    .pc_redirect(pc_redirect),
`ifdef PIPE_CTRL_PERF_EN
    .halted(halted), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .halt_cnt(halt_cnt)
`else
    .halted(halted)
`endif
  );

  assign obs = {fd_update, de_update, ew_update,
                pc_en, pc_redirect, halted};

  function automatic bit dep(input logic [6:0] x);
    bit is_fp;
    is_fp = de_rw[1];
    if (de_rw == 2'b00) return 0;
    if (is_fp != x[6]) return 0;
    if (de_rd != x[5:0]) return 0;
    if (!is_fp && de_rd == 0) return 0;
    return 1;
  endfunction

  task automatic model_step(output logic [8:0] e);
    bit lu, was_halt;
    lu = de_is_load && ((d_use_s && dep(d_rs)) || (d_use_t && dep(d_rt)));
    was_halt = m_halt;
    e = V_BUSY;
    if (rst) begin
      e = V_RST; m_halt = 0; m_rem = 0;
    end else if (m_halt) begin
      if (resume) begin e = V_RESUM; m_halt = 0; end
      else e = V_HALT;
    end else if (mem_busy) begin
      e = V_BUSY;
    end else if (m_rem > 1) begin
      e = V_STALL; m_rem = m_rem - 1;
    end else if (m_rem == 0 && de_stop) begin
      e = V_STALL; m_halt = 1;
    end else if (m_rem == 0 && de_wait_time != 0) begin
      e = V_STALL; m_rem = int'(de_wait_time);
    end else begin
      m_rem = 0;
      e = e_redirect ? V_REDIR : (lu ? V_LU : V_ADV);
    end
`ifdef PIPE_CTRL_PERF_EN
    if (rst) begin
      m_stall = 0; m_flush = 0; m_hcnt = 0;
    end else begin
      if (!was_halt && !e[2]) m_stall++;
      if (e[1]) m_flush++;
      if (e[0]) m_hcnt++;
    end
`else
    if (was_halt) e = e;
`endif
  endtask

  task automatic idle_in();
    rst = 0; mem_busy = 0; resume = 0;
    d_rs = 0; d_rt = 0; d_use_s = 0; d_use_t = 0;
    de_rw = 0; de_rd = 0; de_is_load = 0;
    de_wait_time = 0; de_stop = 0; e_redirect = 0;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_in();
      rst = (i < 2);
      #1;
      model_step(e);
      n_cmp++;
      if (obs !== e || obs !== (i < 2 ? V_RST : V_ADV)) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got=%b want=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_load_use();
    logic [8:0] e, want;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_in();
      de_is_load = 1; de_rw = 2'b01; de_rd = 6'd5;
      d_use_s = 1; d_rs = 7'h05;
      want = V_LU;
      if (i == 1) begin d_rs = 7'h45; want = V_ADV; end
      if (i == 2) begin de_rd = 0; d_rs = 7'h00; want = V_ADV; end
      if (i == 3) begin
        d_use_s = 0; d_use_t = 1; d_rt = 7'h05; d_rs = 7'h09;
      end
      #1;
      model_step(e);
      n_cmp++;
      if (obs !== e || obs !== want) begin
        n_bad++;
        $display("FAIL load_use cyc=%0d got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_multicycle();
    logic [8:0] e;
    logic [8:0] want [5] = '{V_STALL, V_BUSY, V_STALL, V_STALL, V_ADV};
    int stalls = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_in();
      de_wait_time = 3;
      #1;
      model_step(e);
      if (!obs[2]) stalls++;
      n_cmp++;
      if (obs !== e || obs !== (i < 3 ? V_STALL : V_ADV)) begin
        n_bad++;
        $display("FAIL wait3 cyc=%0d got=%b want=%b", i, obs, e);
      end
    end
    n_cmp++;
    if (stalls != 3) begin
      n_bad++;
      $display("FAIL wait3_len got=%0d want=3", stalls);
    end
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_in();
      de_wait_time = 3;
      mem_busy = (i == 1);
      #1;
      model_step(e);
      if (!obs[2]) stalls++;
      n_cmp++;
      if (obs !== e || obs !== want[i]) begin
        n_bad++;
        $display("FAIL wait3_busy cyc=%0d got=%b want=%b", i, obs, want[i]);
      end
    end
    n_cmp++;
    if (stalls != 4) begin
      n_bad++;
      $display("FAIL wait3_busy_len got=%0d want=4", stalls);
    end
  endtask

  task automatic test_redirect();
    logic [8:0] e;
    logic [8:0] want [4] = '{V_REDIR, V_STALL, V_STALL, V_REDIR};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_in();
      de_is_load = 1; de_rw = 2'b01; de_rd = 6'd5;
      d_use_s = 1; d_rs = 7'h05;
      e_redirect = 1;
      if (i > 0) begin de_is_load = 0; de_wait_time = 2; end
      #1;
      model_step(e);
      n_cmp++;
      if (obs !== e || obs !== want[i]) begin
        n_bad++;
        $display("FAIL redirect cyc=%0d got=%b want=%b", i, obs, want[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [8:0] e, want;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      idle_in();
      want = V_HALT;
      if (i == 0) begin de_stop = 1; want = V_STALL; end
      if (i == 5) begin mem_busy = 1; e_redirect = 1; end
      if (i == 11) begin resume = 1; mem_busy = 1; want = V_RESUM; end
      if (i == 12) want = V_ADV;
      #1;
      model_step(e);
      n_cmp++;
      if (obs !== e || obs !== want) begin
        n_bad++;
        $display("FAIL halt cyc=%0d got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst          = ($urandom_range(63) == 0);
      mem_busy     = ($urandom_range(5) == 0);
      resume       = ($urandom_range(7) == 0);
      d_rs         = {1'($urandom), 6'($urandom_range(3))};
      d_rt         = {1'($urandom), 6'($urandom_range(3))};
      d_use_s      = 1'($urandom);
      d_use_t      = 1'($urandom);
      de_rw        = 2'($urandom);
      de_rd        = 6'($urandom_range(3));
      de_is_load   = 1'($urandom);
      de_wait_time = ($urandom_range(9) < 7) ? '0
                     : WAIT_W'($urandom_range(1, 4));
      de_stop      = ($urandom_range(15) == 0);
      e_redirect   = ($urandom_range(4) == 0);
      #1;
      model_step(e);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_perf();
`ifdef PIPE_CTRL_PERF_EN
    @(posedge clk);
    #1;
    n_cmp++;
    if (stall_cnt !== 32'(m_stall)) begin
      n_bad++;
      $display("FAIL stall_cnt got=%0d want=%0d", stall_cnt, m_stall);
    end
    n_cmp++;
    if (flush_cnt !== 32'(m_flush)) begin
      n_bad++;
      $display("FAIL flush_cnt got=%0d want=%0d", flush_cnt, m_flush);
    end
    n_cmp++;
    if (halt_cnt !== 32'(m_hcnt)) begin
      n_bad++;
      $display("FAIL halt_cnt got=%0d want=%0d", halt_cnt, m_hcnt);
    end
`endif
  endtask

  initial begin
    idle_in();
    rst = 1;
    test_reset();
    test_load_use();
    test_multicycle();
    test_redirect();
    test_halt();
    test_perf();
    test_random();
    @(negedge clk);
    idle_in();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
